// File: rtl/pwm_feed_if.sv
// Upstream sample handshake into pwm_feed.
// 24-bit offset-binary samples, valid/ready.
interface pwm_feed_if;
  logic        in_valid;
  logic [23:0] in_data;
  logic        in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/pwm_feed.sv
// Frame-aligned sample feeder for pwm: FIFO, priming, underrun mute.
// Optional PWM_FEED_UFLOW_CNT_EN enables the saturating underrun counter.
module pwm_feed #(
  parameter int DEPTH       = 4,
  parameter int PRIME_LEVEL = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          mck,
  input  logic          rst_n,
  pwm_feed_if.slave     up,
  input  logic [4:0]    pwm_count,
  output logic [23:0]   pwm_sample,
  output logic [LW-1:0] level,
  output logic          running,
  output logic          underrun,
  output logic [7:0]    uflow_cnt
);

  localparam logic [23:0] SILENCE = 24'h800000;

  typedef enum logic {
    FILL,
    RUN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic        bnd;
  logic        push;
  logic        pop;
  logic        empty;
  logic        primed;
  logic [23:0] sample_d;
  logic        underrun_d;

  // No push-through: a full FIFO refuses even when a pop is due.
  assign up.in_ready = rst_n && (level != LW'(DEPTH));

  assign push   = up.in_valid && up.in_ready;
  assign bnd    = pwm_count == 5'd31;
  assign empty  = level == '0;
  assign primed = level >= LW'(PRIME_LEVEL);

  assign running = state_q == RUN;

  always_comb begin
    state_d    = state_q;
    sample_d   = pwm_sample;
    pop        = 1'b0;
    underrun_d = 1'b0;
    if (bnd) begin
      unique case (state_q)
        FILL: begin
          sample_d = SILENCE;
          if (primed) begin
            state_d = RUN;
          end
        end
        RUN: begin
          // Underrun is judged on the pre-push level.
          if (empty) begin
            sample_d   = SILENCE;
            underrun_d = 1'b1;
            state_d    = FILL;
          end else begin
            sample_d = mem[rd_ptr];
            pop      = 1'b1;
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge mck) begin
    if (!rst_n) begin
      state_q    <= FILL;
      pwm_sample <= SILENCE;
      underrun   <= 1'b0;
      level      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state_q    <= state_d;
      pwm_sample <= sample_d;
      underrun   <= underrun_d;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case (1'b1)
        push && !pop: level <= level + LW'(1);
        pop && !push: level <= level - LW'(1);
        default:      level <= level;
      endcase
    end
  end

  always_ff @(posedge mck) begin
    if (push) begin
      mem[wr_ptr] <= up.in_data;
    end
  end

`ifdef PWM_FEED_UFLOW_CNT_EN
  logic [7:0] uflow_q;

  always_ff @(posedge mck) begin
    if (!rst_n) begin
      uflow_q <= 8'd0;
    end else if (underrun_d && (uflow_q != 8'hFF)) begin
      uflow_q <= uflow_q + 8'd1;
    end
  end

  assign uflow_cnt = uflow_q;
`else
  assign uflow_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pwm_feed.sv
// Scoreboard bench for pwm_feed: priming, full FIFO,
// underrun, push-on-empty, mid-stream reset, counter saturation.
module tb_pwm_feed;

  logic        mck = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  pwm_count = 5'd0;
  logic        hold31 = 1'b0;
  logic [23:0] pwm_sample;
  logic [2:0]  level;
  logic        running;
  logic        underrun;
  logic [7:0]  uflow_cnt;

  int checks = 0;
  int errors = 0;
  int exp_uflow = 0;
  logic [7:0]  exp_cnt;
  logic [23:0] exp_q[$];
  logic [23:0] e;

  pwm_feed_if up ();

  pwm_feed #(
    .DEPTH(4),
    .PRIME_LEVEL(2)
  ) dut (
    .mck(mck),
    .rst_n(rst_n),
    .up(up),
    .pwm_count(pwm_count),
    .pwm_sample(pwm_sample),
    .level(level),
    .running(running),
    .underrun(underrun),
    .uflow_cnt(uflow_cnt)
  );

  always #5 mck = ~mck;

  always @(posedge mck)
    pwm_count <= hold31 ? 5'd31 : pwm_count + 5'd1;

  task automatic step;
    @(posedge mck);
    #1;
  endtask

  task automatic calc_cnt;
`ifdef PWM_FEED_UFLOW_CNT_EN
    exp_cnt = (exp_uflow > 255) ? 8'd255 : 8'(exp_uflow);
`else
    exp_cnt = 8'd0;
`endif
  endtask

  task automatic wait_count(input logic [4:0] c);
    int n;
    n = 0;
    while (pwm_count !== c && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (pwm_count !== c) begin
      errors++;
      $display("FAIL wait_count: pwm_count=%0d required %0d", pwm_count, c);
    end
  endtask

  task automatic wait_bnd;
    wait_count(5'd31);
    step();
  endtask

  task automatic push(input logic [23:0] d);
    up.in_valid = 1'b1;
    up.in_data  = d;
    if (up.in_ready === 1'b1) exp_q.push_back(d);
    step();
    up.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (pwm_sample !== 24'h800000) begin
      errors++;
      $display("FAIL reset_sample: got %h required 800000", pwm_sample);
    end
    checks++;
    if (level !== 3'd0 || running !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: level=%0d running=%b underrun=%b required 0/0/0",
               level, running, underrun);
    end
    checks++;
    if (uflow_cnt !== 8'd0 || up.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt_ready: uflow=%0d in_ready=%b required 0/0",
               uflow_cnt, up.in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (up.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b required 1", up.in_ready);
    end
  endtask

  task automatic test_prime_underrun;
    wait_count(5'd0);
    push(24'h100000);
    push(24'h200000);
    checks++;
    if (level !== 3'd2 || running !== 1'b0) begin
      errors++;
      $display("FAIL prime_level: level=%0d running=%b required 2/0", level, running);
    end
    wait_bnd();
    checks++;
    if (running !== 1'b1 || pwm_sample !== 24'h800000 || level !== 3'd2) begin
      errors++;
      $display("FAIL prime_run: running=%b sample=%h level=%0d required 1/800000/2",
               running, pwm_sample, level);
    end
    wait_bnd();
    e = exp_q.pop_front();
    checks++;
    if (pwm_sample !== e) begin
      errors++;
      $display("FAIL prime_pop1: got %h required %h", pwm_sample, e);
    end
    repeat (5) step();
    checks++;
    if (pwm_sample !== e) begin
      errors++;
      $display("FAIL hold_frame: got %h required %h", pwm_sample, e);
    end
    wait_bnd();
    e = exp_q.pop_front();
    checks++;
    if (pwm_sample !== e || level !== 3'd0) begin
      errors++;
      $display("FAIL prime_pop2: got %h level %0d required %h level 0",
               pwm_sample, level, e);
    end
    wait_bnd();
    exp_uflow++;
    checks++;
    if (pwm_sample !== 24'h800000 || underrun !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL underrun: sample=%h underrun=%b running=%b required 800000/1/0",
               pwm_sample, underrun, running);
    end
    step();
    calc_cnt();
    checks++;
    if (underrun !== 1'b0 || uflow_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL underrun_pulse: underrun=%b uflow=%0d required 0/%0d",
               underrun, uflow_cnt, exp_cnt);
    end
  endtask

  task automatic test_full;
    wait_count(5'd0);
    for (int i = 1; i <= 4; i++) push(24'hA00000 + 24'(i));
    checks++;
    if (level !== 3'd4 || up.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full: level=%0d in_ready=%b required 4/0", level, up.in_ready);
    end
    push(24'hFFFFFF);
    checks++;
    if (level !== 3'd4) begin
      errors++;
      $display("FAIL full_drop: level=%0d required 4", level);
    end
    wait_bnd();
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL full_run: running=%b required 1", running);
    end
    for (int i = 0; i < 4; i++) begin
      wait_bnd();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hXXXXXX;
      checks++;
      if (pwm_sample !== e) begin
        errors++;
        $display("FAIL full_pop%0d: got %h required %h", i, pwm_sample, e);
      end
    end
    wait_bnd();
    exp_uflow++;
    checks++;
    if (pwm_sample !== 24'h800000 || underrun !== 1'b1) begin
      errors++;
      $display("FAIL full_underrun: sample=%h underrun=%b required 800000/1",
               pwm_sample, underrun);
    end
  endtask

  task automatic test_push_on_empty;
    wait_count(5'd0);
    push(24'h111111);
    push(24'h222222);
    wait_bnd();
    for (int i = 0; i < 2; i++) begin
      wait_bnd();
      e = exp_q.pop_front();
      checks++;
      if (pwm_sample !== e) begin
        errors++;
        $display("FAIL poe_pop%0d: got %h required %h", i, pwm_sample, e);
      end
    end
    wait_count(5'd31);
    push(24'h345678);
    exp_uflow++;
    checks++;
    if (underrun !== 1'b1 || running !== 1'b0 || level !== 3'd1 ||
        pwm_sample !== 24'h800000) begin
      errors++;
      $display("FAIL poe_underrun: underrun=%b running=%b level=%0d sample=%h required 1/0/1/800000",
               underrun, running, level, pwm_sample);
    end
    wait_count(5'd0);
    push(24'h456789);
    wait_bnd();
    for (int i = 0; i < 2; i++) begin
      wait_bnd();
      e = exp_q.pop_front();
      checks++;
      if (pwm_sample !== e) begin
        errors++;
        $display("FAIL poe_repop%0d: got %h required %h", i, pwm_sample, e);
      end
    end
    wait_bnd();
    exp_uflow++;
    step();
    calc_cnt();
    checks++;
    if (uflow_cnt !== exp_cnt || running !== 1'b0) begin
      errors++;
      $display("FAIL poe_cnt: uflow=%0d running=%b required %0d/0",
               uflow_cnt, running, exp_cnt);
    end
  endtask

  task automatic test_reset_mid;
    wait_count(5'd0);
    push(24'hD00001);
    push(24'hD00002);
    push(24'hD00003);
    wait_bnd();
    wait_count(5'd10);
    checks++;
    if (level !== 3'd3 || running !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: level=%0d running=%b required 3/1", level, running);
    end
    rst_n = 1'b0;
    up.in_valid = 1'b1;
    up.in_data  = 24'h0BAD00;
    step();
    rst_n = 1'b1;
    up.in_valid = 1'b0;
    exp_q.delete();
    exp_uflow = 0;
    calc_cnt();
    checks++;
    if (level !== 3'd0 || pwm_sample !== 24'h800000 || running !== 1'b0 ||
        uflow_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL mid_reset: level=%0d sample=%h running=%b uflow=%0d required 0/800000/0/%0d",
               level, pwm_sample, running, uflow_cnt, exp_cnt);
    end
    wait_bnd();
    checks++;
    if (pwm_sample !== 24'h800000 || level !== 3'd0 || running !== 1'b0) begin
      errors++;
      $display("FAIL mid_nopop: sample=%h level=%0d running=%b required 800000/0/0",
               pwm_sample, level, running);
    end
  endtask

`ifdef PWM_FEED_UFLOW_CNT_EN
  task automatic test_saturation;
    int n;
    hold31 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      up.in_valid = 1'b1;
      up.in_data  = 24'(i);
      step();
      step();
      up.in_valid = 1'b0;
      n = 0;
      while (underrun !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      checks++;
      if (underrun !== 1'b1) begin
        errors++;
        $display("FAIL sat_underrun%0d: underrun=%b required 1", i, underrun);
        break;
      end
      exp_uflow++;
    end
    hold31 = 1'b0;
    step();
    calc_cnt();
    checks++;
    if (uflow_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL saturation: uflow=%0d required %0d", uflow_cnt, exp_cnt);
    end
  endtask
`endif

  initial begin
    up.in_valid = 1'b0;
    up.in_data  = 24'd0;
    test_reset();
    test_prime_underrun();
    test_full();
    test_push_on_empty();
    test_reset_mid();
`ifdef PWM_FEED_UFLOW_CNT_EN
    test_saturation();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_feed.md
# pwm_feed

Sample scheduler for the `pwm` modulator in the pedal output path. It accepts 24-bit audio samples from the upstream DSP chain through a valid/ready handshake and buffers them in a small FIFO. It presents one sample to the PWM per 32-cycle PWM frame, changing it only at frame boundaries. It also handles startup priming and underrun muting so the PWM never outputs a torn or stale sample.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `PRIME_LEVEL`, 2: FIFO occupancy required before playback starts; range 1..DEPTH.

Ports:
- `mck` in 1: master clock, shared with `pwm`.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: upstream sample valid.
- `in_data` in 24: upstream sample, offset binary; 0x800000 is silence.
- `in_ready` out 1: FIFO can accept a sample.
- `pwm_count` in 5: free-running frame counter from `pwm`.
- `pwm_sample` out 24: registered sample driven to `pwm`.
- `level` out $clog2(DEPTH)+1: current FIFO occupancy.
- `running` out 1: high in state RUN.
- `underrun` out 1: one-cycle pulse on each underrun.
- `uflow_cnt` out 8: saturating underrun count; see Configuration.

## Operation

- Push: a push happens in any cycle where `in_valid && in_ready`. `in_data` is written at the FIFO tail.
- `in_ready = rst_n && (level != DEPTH)`. It is deasserted when full, even in a cycle where a pop also occurs; no push-through when full.
- Boundary strobe: `bnd = (pwm_count == 5'd31)`. All `pwm_sample` updates and state transitions happen only on `bnd` cycles.
- FSM, state FILL (reset state):
  - On each `bnd`, load `pwm_sample` with 0x800000.
  - If `level >= PRIME_LEVEL` at `bnd`, go to RUN. This `bnd` does not pop.
- FSM, state RUN:
  - On `bnd` with `level > 0`: pop the head into `pwm_sample`, stay in RUN.
  - On `bnd` with `level == 0`: underrun. Load 0x800000, pulse `underrun`, go to FILL.
- Simultaneous push and pop: `level` is unchanged and both operations complete.
- Push on the same `bnd` that sees `level == 0`: still an underrun, decided on the pre-push level. The pushed data is kept in the FIFO.
- Pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH. `level` is an explicit counter, not derived from pointers.
- No data-dependent arithmetic on samples; values pass through bit-exact.

## Timing

- Reset (`rst_n` low at a `mck` rising edge), on the following edge:
  - `pwm_sample` = 0x800000
  - `level` = 0
  - `running` = 0
  - `underrun` = 0
  - `uflow_cnt` = 0
  - pointers = 0
  - state = FILL
- Reset mid-operation discards FIFO contents and any in-flight push.
- `in_ready` is combinational from `level` and `rst_n`, with no latency.
- Push to `level` increment: 1 cycle.
- Pop: `pwm_sample` updates on the edge ending the `bnd` cycle. The new value is therefore stable for the whole frame in which `pwm_count` runs 0..31.
- `running` and `underrun` are registered and change on that same edge. `underrun` is high for exactly one cycle.
- Minimum latency from the first push after reset to that sample appearing on `pwm_sample` is two boundaries, assuming `PRIME_LEVEL` is reached before the first one: one `bnd` enters RUN, the next `bnd` pops.
- `pwm_sample` is never modified when `bnd` is low.

## Configuration

- `PWM_FEED_UFLOW_CNT_EN` defined: `uflow_cnt` increments on each `underrun` pulse. It saturates at 255 and clears only on reset.
- Not defined: `uflow_cnt` is tied to 8'd0 and the counter logic is not compiled. The port is always present.

## Test plan

- Reset and priming, DEPTH=4, PRIME_LEVEL=2:
  - After reset: `pwm_sample`=0x800000, `in_ready`=1, `running`=0.
  - Push 0x100000 and 0x200000 before the first `bnd`: `running` rises after the first `bnd`.
  - `pwm_sample`=0x100000 after the second `bnd`, and 0x200000 after the third.
- Full FIFO:
  - Push 4 samples during FILL with PRIME_LEVEL=4: `level`=4 and `in_ready`=0.
  - A fifth `in_valid` with 0xFFFFFF is dropped. The pops that follow give only the first four values, in order.
- Underrun: in RUN with `level`=1:
  - After the next `bnd`, `pwm_sample` holds the last sample.
  - At the following `bnd`, `pwm_sample` becomes 0x800000, `underrun` pulses for 1 cycle, and `running`=0.
  - With the macro defined, `uflow_cnt` becomes 1.
- Push on an empty `bnd` in RUN: still an underrun, `level`=1 afterwards, and the pushed value is output after re-priming.
- Reset mid-stream: assert `rst_n`=0 for 1 cycle while `level`=3 and `pwm_count`=10. The next edge gives `level`=0 and `pwm_sample`=0x800000. Nothing is popped at the next `bnd`.
- Saturation (macro defined): force 300 underruns; `uflow_cnt` stays at 255.
